// File: rtl/instr_prefetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_queue_if
// Description : Bundles the consumer-side handshake (stall / flush / head
//               outputs) and the instruction-memory request bus of the
//               instruction prefetch queue.
//               master : seen from the prefetch queue
//               slave  : seen from the surrounding pipeline + memory
// Ports (signals):
//   stall      consumer not taking the head entry this cycle
//   flush      redirect request (branch taken / jump)
//   flush_pc   redirect target
//   imem_req   memory request (registered)
//   imem_addr  memory request address (registered, word aligned)
//   imem_ack   memory returns data this cycle
//   imem_rdata instruction word returned with imem_ack
//   pc_out     PC of head entry
//   instr_out  instruction of head entry
//   ready      queue non-empty, head valid
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_prefetch_queue_if #(
  parameter int WIDTH = 32
);

  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] flush_pc;
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] instr_out;
  logic             ready;

  modport master (
    input  stall,
    input  flush,
    input  flush_pc,
    input  imem_ack,
    input  imem_rdata,
    output imem_req,
    output imem_addr,
    output pc_out,
    output instr_out,
    output ready
  );

  modport slave (
    output stall,
    output flush,
    output flush_pc,
    output imem_ack,
    output imem_rdata,
    input  imem_req,
    input  imem_addr,
    input  pc_out,
    input  instr_out,
    input  ready
  );

endinterface
`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_prefetch_queue
// Description : Instruction prefetch queue. Fetches sequential instruction
//               words from instruction memory (one outstanding request at a
//               time) into a DEPTH-entry circular buffer of {pc, instr} and
//               presents the oldest entry to the decode stage. A flush from
//               execute empties the queue and redirects fetching; a request
//               that is still in flight at that moment is completed on the
//               bus and its data thrown away.
// Parameters  :
//   WIDTH     instruction / address width
//   DEPTH     number of queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
// Ports       :
//   clk       clock, all state updates on the rising edge
//   rst       asynchronous active-high reset
//   bus       instr_prefetch_queue_if.master (see interface for signals)
// Revision    : 1.0 - initial release
// ============================================================================
module instr_prefetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_prefetch_queue_if.master bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [WIDTH-1:0] c_nop   = WIDTH'(32'h0000_0013);
  localparam logic [WIDTH-1:0] c_step  = WIDTH'(4);
  localparam logic [WIDTH-1:0] c_align = ~WIDTH'(3);

  // Fetch FSM encoding
  localparam logic [1:0] c_st_idle    = 2'd0;  // no request outstanding
  localparam logic [1:0] c_st_wait    = 2'd1;  // request outstanding, data wanted
  localparam logic [1:0] c_st_discard = 2'd2;  // request outstanding, data dropped

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic             r_req;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_fetch_pc;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;

  logic [WIDTH-1:0] r_pc_mem    [DEPTH];
  logic [WIDTH-1:0] r_instr_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic             w_xfer;
  logic             w_pop;
  logic             w_push;
  logic             w_not_empty;
  logic [CNT_W-1:0] w_count_next;
  logic             w_space;
  logic [WIDTH-1:0] w_flush_target;
  logic [WIDTH-1:0] w_fetch_inc;

  logic [1:0]       w_state_next;
  logic             w_req_next;
  logic [WIDTH-1:0] w_addr_next;
  logic [WIDTH-1:0] w_fetch_next;

  assign w_not_empty    = (r_count != '0);
  assign w_xfer         = r_req && bus.imem_ack;
  assign w_pop          = w_not_empty && !bus.stall;
  // Only a WAIT-state transfer carries wanted data; flush kills it too.
  assign w_push         = w_xfer && (r_state == c_st_wait) && !bus.flush;
  assign w_count_next   = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  // Room for one more word once this edge's push/pop have happened; this is
  // what lets a new request go out without ever overfilling the queue.
  assign w_space        = (w_count_next < c_depth);
  assign w_flush_target = bus.flush_pc & c_align;
  assign w_fetch_inc    = r_fetch_pc + c_step;

  // --------------------------------------------------------------------------
  // Fetch FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_req_next   = r_req;
    w_addr_next  = r_addr;
    w_fetch_next = r_fetch_pc;

    case (r_state)
      c_st_idle: begin
        if (bus.flush) begin
          // Redirect only; the request to the new target goes out next edge.
          w_fetch_next = w_flush_target;
        end else if (w_space) begin
          w_state_next = c_st_wait;
          w_req_next   = 1'b1;
          w_addr_next  = r_fetch_pc;
        end
      end

      c_st_wait: begin
        if (bus.flush) begin
          w_fetch_next = w_flush_target;
          if (w_xfer) begin
            w_state_next = c_st_idle;
            w_req_next   = 1'b0;
          end else begin
            // Bus request cannot be withdrawn: keep it at the old address
            // and throw its data away when it finally arrives.
            w_state_next = c_st_discard;
          end
        end else if (w_xfer) begin
          w_fetch_next = w_fetch_inc;
          if (w_space) begin
            // Back-to-back request keeps one word per cycle on zero-wait memory.
            w_addr_next = w_fetch_inc;
          end else begin
            w_state_next = c_st_idle;
            w_req_next   = 1'b0;
          end
        end
      end

      c_st_discard: begin
        if (bus.flush) begin
          w_fetch_next = w_flush_target;
        end
        if (w_xfer) begin
          w_state_next = c_st_idle;
          w_req_next   = 1'b0;
        end
      end

      default: begin
        w_state_next = c_st_idle;
        w_req_next   = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch FSM / request registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_req      <= w_req_next;
      r_addr     <= w_addr_next;
      r_fetch_pc <= w_fetch_next;
    end
  end

  // --------------------------------------------------------------------------
  // Queue bookkeeping: flush wins over both push and pop
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (bus.flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count <= w_count_next;
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
    end
  end

  // Entry storage needs no reset: head outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_addr;
      r_instr_mem[r_wr_ptr] <= bus.imem_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_addr;
  assign bus.ready     = w_not_empty;
  assign bus.pc_out    = w_not_empty ? r_pc_mem[r_rd_ptr]    : '0;
  assign bus.instr_out = w_not_empty ? r_instr_mem[r_rd_ptr] : c_nop;

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_prefetch_queue
// Description : Self-checking bench for instr_prefetch_queue. A memory model
//               answers requests with a hashed word of the address, and a
//               queue of expected {pc, instr} entries tracks what the decode
//               stage must see. Directed scenarios plus a randomized run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_queue;

  localparam int          WIDTH    = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int tests = 0;
  int fails = 0;

  instr_prefetch_queue_if #(.WIDTH(WIDTH)) bus ();

  instr_prefetch_queue #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [63:0] q[$];        // expected queue contents {pc, instr}
  logic [31:0] exp_addr;    // address the next fresh request must use
  bit          discard;     // outstanding request's data must be dropped
  bit          prev_req;
  bit          prev_xfer;
  logic [31:0] prev_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  task automatic model_reset();
    q.delete();
    exp_addr  = RESET_PC;
    discard   = 1'b0;
    prev_req  = 1'b0;
    prev_xfer = 1'b0;
    prev_addr = '0;
  endtask

  // Apply one cycle of inputs (just after a falling edge), advance the model
  // by the same rising edge, and return at the following falling edge.
  task automatic drive_cycle(input logic s, input logic f, input logic [31:0] fp, input logic a);
    bit xfer;
    bus.stall      = s;
    bus.flush      = f;
    bus.flush_pc   = fp;
    bus.imem_ack   = a;
    bus.imem_rdata = mem_word(bus.imem_addr);
    xfer = bus.imem_req && a;
    if (f) begin
      q.delete();
      exp_addr = {fp[31:2], 2'b00};
      discard  = bus.imem_req && !xfer;
    end else begin
      if (q.size() != 0 && !s) void'(q.pop_front());
      if (xfer) begin
        if (!discard) begin
          q.push_back({bus.imem_addr, mem_word(bus.imem_addr)});
          exp_addr = bus.imem_addr + 32'd4;
        end
        discard = 1'b0;
      end
    end
    prev_req  = bus.imem_req;
    prev_xfer = xfer;
    prev_addr = bus.imem_addr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 0; bus.flush = 0; bus.flush_pc = '0; bus.imem_ack = 0; bus.imem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %0b expected 0", bus.imem_req); end
    tests++; if (bus.imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %0h expected 0", bus.imem_addr); end
    tests++; if (bus.ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %0b expected 0", bus.ready); end
    tests++; if (bus.instr_out !== NOP) begin fails++; $display("FAIL reset_instr: got %0h expected %0h", bus.instr_out, NOP); end
    tests++; if (bus.pc_out !== 32'h0) begin fails++; $display("FAIL reset_pc: got %0h expected 0", bus.pc_out); end
    drive_cycle(0, 0, '0, 0);
    tests++; if (bus.imem_req !== 1'b1) begin fails++; $display("FAIL first_req: got %0b expected 1", bus.imem_req); end
    tests++; if (bus.imem_addr !== RESET_PC) begin fails++; $display("FAIL first_addr: got %0h expected %0h", bus.imem_addr, RESET_PC); end
  endtask

  task automatic test_zero_wait();
    for (int k = 1; k <= 8; k++) begin
      drive_cycle(0, 0, '0, 1);
      tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL zw_ready[%0d]: got %0b expected 1", k, bus.ready); end
      tests++; if (bus.pc_out !== 32'(4 * (k - 1))) begin fails++; $display("FAIL zw_pc[%0d]: got %0h expected %0h", k, bus.pc_out, 4 * (k - 1)); end
      tests++; if (bus.instr_out !== mem_word(32'(4 * (k - 1)))) begin fails++; $display("FAIL zw_instr[%0d]: got %0h expected %0h", k, bus.instr_out, mem_word(32'(4 * (k - 1)))); end
      tests++; if (bus.imem_addr !== 32'(4 * k)) begin fails++; $display("FAIL zw_addr[%0d]: got %0h expected %0h", k, bus.imem_addr, 4 * k); end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1, 0, '0, 1);
      tests++; if (bus.pc_out !== 32'd28 || bus.ready !== 1'b1) begin fails++; $display("FAIL stall_hold[%0d]: got pc %0h ready %0b expected pc 1c ready 1", k, bus.pc_out, bus.ready); end
    end
    tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL stall_req_drop: got %0b expected 0", bus.imem_req); end
    tests++; if (q.size() != DEPTH) begin fails++; $display("FAIL stall_full: got %0d entries expected %0d", q.size(), DEPTH); end
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(0, 0, '0, 1);
      tests++; if (bus.pc_out !== 32'(28 + 4 * i) || bus.instr_out !== mem_word(32'(28 + 4 * i))) begin fails++; $display("FAIL stall_release[%0d]: got pc %0h instr %0h expected pc %0h", i, bus.pc_out, bus.instr_out, 28 + 4 * i); end
    end
  endtask

  task automatic test_flush_queue();
    for (int i = 0; i < 10 && q.size() < 3; i++) drive_cycle(1, 0, '0, 1);
    tests++; if (q.size() != 3 || bus.ready !== 1'b1) begin fails++; $display("FAIL fq_fill: got %0d entries ready %0b expected 3 entries ready 1", q.size(), bus.ready); end
    drive_cycle(1, 1, 32'h40, 0);
    tests++; if (bus.ready !== 1'b0 || bus.instr_out !== NOP || bus.pc_out !== 32'h0) begin fails++; $display("FAIL fq_empty: got ready %0b instr %0h pc %0h expected 0/13/0", bus.ready, bus.instr_out, bus.pc_out); end
    drive_cycle(0, 0, '0, 1);
    tests++; if (bus.imem_req !== 1'b0 || bus.ready !== 1'b0) begin fails++; $display("FAIL fq_drop: got req %0b ready %0b expected 0 0", bus.imem_req, bus.ready); end
    drive_cycle(0, 0, '0, 0);
    tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin fails++; $display("FAIL fq_newreq: got req %0b addr %0h expected 1 40", bus.imem_req, bus.imem_addr); end
    drive_cycle(0, 0, '0, 1);
    tests++; if (bus.ready !== 1'b1 || bus.pc_out !== 32'h40 || bus.instr_out !== mem_word(32'h40)) begin fails++; $display("FAIL fq_head: got ready %0b pc %0h expected 1 40", bus.ready, bus.pc_out); end
  endtask

  task automatic test_flush_wait();
    drive_cycle(0, 1, 32'h300, 0);
    for (int k = 0; k < 4; k++) begin
      tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h44 || bus.ready !== 1'b0) begin fails++; $display("FAIL fw_discard[%0d]: got req %0b addr %0h ready %0b expected 1 44 0", k, bus.imem_req, bus.imem_addr, bus.ready); end
      if (k < 3) drive_cycle(0, 0, '0, 0);
    end
    drive_cycle(0, 0, '0, 1);
    tests++; if (bus.imem_req !== 1'b0 || bus.ready !== 1'b0) begin fails++; $display("FAIL fw_dropped: got req %0b ready %0b expected 0 0", bus.imem_req, bus.ready); end
    drive_cycle(0, 0, '0, 0);
    tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300) begin fails++; $display("FAIL fw_newreq: got req %0b addr %0h expected 1 300", bus.imem_req, bus.imem_addr); end
    drive_cycle(0, 0, '0, 1);
    tests++; if (bus.pc_out !== 32'h300 || bus.instr_out !== mem_word(32'h300)) begin fails++; $display("FAIL fw_head: got pc %0h instr %0h expected pc 300", bus.pc_out, bus.instr_out); end
  endtask

  task automatic test_flush_ack();
    drive_cycle(0, 1, 32'h100, 1);
    tests++; if (bus.imem_req !== 1'b0 || bus.ready !== 1'b0) begin fails++; $display("FAIL fa_drop: got req %0b ready %0b expected 0 0", bus.imem_req, bus.ready); end
    drive_cycle(0, 0, '0, 0);
    tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin fails++; $display("FAIL fa_newreq: got req %0b addr %0h expected 1 100", bus.imem_req, bus.imem_addr); end
    drive_cycle(0, 0, '0, 1);
    tests++; if (bus.pc_out !== 32'h100 || bus.imem_addr !== 32'h104) begin fails++; $display("FAIL fa_head: got pc %0h addr %0h expected 100 104", bus.pc_out, bus.imem_addr); end
    drive_cycle(0, 1, 32'h103, 1);
    drive_cycle(0, 0, '0, 0);
    tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin fails++; $display("FAIL fa_align: got req %0b addr %0h expected 1 100", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_reset_mid();
    drive_cycle(1, 0, '0, 1);
    drive_cycle(1, 0, '0, 1);
    tests++; if (q.size() != 2 || bus.ready !== 1'b1 || bus.imem_req !== 1'b1) begin fails++; $display("FAIL rm_setup: got %0d entries ready %0b req %0b expected 2 1 1", q.size(), bus.ready, bus.imem_req); end
    rst = 1'b1;
    bus.imem_ack = 1'b1;
    #1;
    tests++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin fails++; $display("FAIL rm_async_req: got req %0b addr %0h expected 0 0", bus.imem_req, bus.imem_addr); end
    tests++; if (bus.ready !== 1'b0 || bus.instr_out !== NOP || bus.pc_out !== 32'h0) begin fails++; $display("FAIL rm_async_head: got ready %0b instr %0h pc %0h expected 0 13 0", bus.ready, bus.instr_out, bus.pc_out); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    drive_cycle(0, 0, '0, 1);
    tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC || bus.ready !== 1'b0) begin fails++; $display("FAIL rm_restart: got req %0b addr %0h ready %0b expected 1 %0h 0", bus.imem_req, bus.imem_addr, bus.ready, RESET_PC); end
    drive_cycle(0, 0, '0, 1);
    tests++; if (bus.ready !== 1'b1 || bus.pc_out !== RESET_PC || bus.instr_out !== mem_word(RESET_PC)) begin fails++; $display("FAIL rm_head: got ready %0b pc %0h expected 1 %0h", bus.ready, bus.pc_out, RESET_PC); end
  endtask

  task automatic test_random();
    logic s, f, a;
    logic [31:0] fp;
    for (int n = 0; n < 600; n++) begin
      s  = ($urandom_range(0, 9) < 3);
      f  = ($urandom_range(0, 24) == 0);
      fp = 32'($urandom_range(0, 32'h0000_FFFF));
      a  = (n < 200) ? 1'b1 : ($urandom_range(0, 3) != 0);
      drive_cycle(s, f, fp, a);
      tests++; if (bus.ready !== logic'(q.size() != 0)) begin fails++; $display("FAIL rnd_ready[%0d]: got %0b expected %0b", n, bus.ready, q.size() != 0); end
      if (q.size() != 0) begin
        tests++; if ({bus.pc_out, bus.instr_out} !== q[0]) begin fails++; $display("FAIL rnd_head[%0d]: got %0h_%0h expected %0h", n, bus.pc_out, bus.instr_out, q[0]); end
      end else begin
        tests++; if (bus.pc_out !== 32'h0 || bus.instr_out !== NOP) begin fails++; $display("FAIL rnd_empty[%0d]: got pc %0h instr %0h expected 0 13", n, bus.pc_out, bus.instr_out); end
      end
      tests++; if (q.size() > DEPTH) begin fails++; $display("FAIL rnd_overflow[%0d]: got %0d entries expected <= %0d", n, q.size(), DEPTH); end
      if (prev_req && !prev_xfer) begin
        tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr) begin fails++; $display("FAIL rnd_hold[%0d]: got req %0b addr %0h expected 1 %0h", n, bus.imem_req, bus.imem_addr, prev_addr); end
      end else if (bus.imem_req) begin
        tests++; if (bus.imem_addr !== exp_addr) begin fails++; $display("FAIL rnd_addr[%0d]: got %0h expected %0h", n, bus.imem_addr, exp_addr); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_flush_queue();
    test_flush_wait();
    test_flush_ack();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
